transpose_stream_ctrl: RTL and testbench

- Sequencer for the 32x32 streaming transpose core inside the AFU.
- Issues input-FIFO reads and generates the core's clk_en/start, with credit-based backpressure from the output FIFO.
- Issues exactly ctx_length output-FIFO writes per context, then flushes the pipeline with bubble cycles and signals done.
- Replaces the ad-hoc free-running clk_en scheme, which has no backpressure and no end-of-context handling.

---
 rtl/afu_ctrl_pkg.sv | 18 +
 rtl/transpose_stream_ctrl_if.sv | 34 +++
 rtl/credit_counter.sv | 43 ++++
 rtl/transpose_stream_ctrl.sv | 143 ++++++++++++++
 tb/tb_transpose_stream_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/afu_ctrl_pkg.sv
// Shared AFU controller definitions: FSM state encoding and the transpose
// core geometry constants used by the stream sequencer and its bench.
package afu_ctrl_pkg;

  // Rows per transpose block; fixed by the 32x32 core.
  localparam int BLOCK_ROWS = 32;

  // Width of context length and row counters.
  localparam int LEN_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/transpose_stream_ctrl_if.sv
// Stream-side handshakes of the transpose sequencer: input FIFO pop, core
// enable/start, core output valid and output FIFO push/pop.
// master = the sequencer, slave = the surrounding FIFOs and core.
interface transpose_stream_ctrl_if;

  logic in_fifo_empty;
  logic in_fifo_re;
  logic core_clk_en;
  logic core_start;
  logic core_start_next_stage;
  logic out_fifo_we;
  logic out_fifo_re;

  modport master (
    input  in_fifo_empty,
    input  core_start_next_stage,
    input  out_fifo_re,
    output in_fifo_re,
    output core_clk_en,
    output core_start,
    output out_fifo_we
  );

  modport slave (
    output in_fifo_empty,
    output core_start_next_stage,
    output out_fifo_re,
    input  in_fifo_re,
    input  core_clk_en,
    input  core_start,
    input  out_fifo_we
  );

endinterface

// File: rtl/credit_counter.sv
// Credit counter for a downstream FIFO of DEPTH entries. An issue reserves
// one credit for exactly one cycle; on that following cycle the credit is
// either consumed (downstream push) or silently returned. External pops
// give credits back, saturating at DEPTH because a pop of an empty FIFO
// frees nothing.
module credit_counter #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reserve,
  input  logic             consume,
  input  logic             credit_return,
  output logic [CNT_W-1:0] avail
);

  logic [CNT_W-1:0] credits;
  logic             reserved;
  logic             inc;
  logic             dec;

  // A push can only use a credit that was reserved the cycle before.
  assign dec   = consume && reserved;
  assign inc   = credit_return && (credits != CNT_W'(DEPTH));
  assign avail = credits - {{(CNT_W-1){1'b0}}, reserved};

  // Credit and reservation registers; push and pop together cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits  <= CNT_W'(DEPTH);
      reserved <= 1'b0;
    end else begin
      reserved <= reserve;
      if (inc && !dec) begin
        credits <= credits + CNT_W'(1);
      end else if (dec && !inc) begin
        credits <= credits - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Sequencer for the 32x32 streaming transpose core. Pops the input FIFO,
// drives core clk_en/start, pushes core output rows into the output FIFO
// under credit backpressure, then flushes the last block with bubbles and
// pulses done once exactly ctx_length rows have been written.
module transpose_stream_ctrl
  import afu_ctrl_pkg::*;
#(
  parameter int OUT_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctx_start,
  input  logic [LEN_W-1:0]        ctx_length,
  transpose_stream_ctrl_if.master strm,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  ctrl_state_e      state;
  ctrl_state_e      state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rows_in;
  logic [LEN_W-1:0] rows_out;
  logic [CNT_W-1:0] avail;
  logic             read_grant;
  logic             bubble_grant;
  logic             en_q;
  logic             start_q;
  logic             write_now;
  logic             len_zero;
  logic             len_ok;
  logic             accept;

  assign len_zero = (ctx_length == '0);
  assign len_ok   = ((ctx_length % LEN_W'(BLOCK_ROWS)) == '0);
  assign accept   = (state == IDLE) && ctx_start;

  // The core only produces a valid row on an enabled cycle.
  assign write_now        = en_q && strm.core_start_next_stage;
  assign strm.out_fifo_we = write_now;
  assign strm.core_clk_en = en_q;
  assign strm.core_start  = start_q;
  assign strm.in_fifo_re  = read_grant;

  credit_counter #(
    .DEPTH (OUT_DEPTH)
  ) u_credits (
    .clk           (clk),
    .reset         (reset),
    .reserve       (read_grant || bubble_grant),
    .consume       (write_now),
    .credit_return (strm.out_fifo_re),
    .avail         (avail)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus issue grants; a bubble is granted only while the rows
  // already written, including this cycle's push, fall short of len.
  always_comb begin
    state_next   = state;
    read_grant   = 1'b0;
    bubble_grant = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (ctx_start) begin
          if (len_zero) begin
            state_next = FINISH;
          end else if (len_ok) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        busy       = 1'b1;
        read_grant = !strm.in_fifo_empty && (rows_in < len) && (avail != '0);
        if ((rows_in == len) && !start_q) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy         = 1'b1;
        bubble_grant = (avail != '0) &&
                       ((rows_out + {{(LEN_W-1){1'b0}}, write_now}) < len);
        if (rows_out == len) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Core enable pipeline, context length, row counters and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      start_q  <= 1'b0;
      len      <= '0;
      rows_in  <= '0;
      rows_out <= '0;
      len_err  <= 1'b0;
    end else begin
      en_q    <= read_grant || bubble_grant;
      start_q <= read_grant;
      if (accept) begin
        if (!len_zero && !len_ok) begin
          len_err <= 1'b1;
        end else begin
          len      <= ctx_length;
          rows_in  <= '0;
          rows_out <= '0;
          len_err  <= 1'b0;
        end
      end else begin
        if (read_grant) begin
          rows_in <= rows_in + LEN_W'(1);
        end
        if (write_now) begin
          rows_out <= rows_out + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Directed bench for transpose_stream_ctrl with models of the input FIFO,
// output FIFO and the 32-enabled-cycle latency of the transpose core.
module tb_transpose_stream_ctrl;
  import afu_ctrl_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ctx_start;
  logic [LEN_W-1:0] ctx_length;
  logic             busy;
  logic             done;
  logic             len_err;

  transpose_stream_ctrl_if ifc();

  transpose_stream_ctrl #(
    .OUT_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .ctx_start  (ctx_start),
    .ctx_length (ctx_length),
    .strm       (ifc),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int in_pushed = 0;
  int in_popped = 0;
  int occ = 0;
  bit overflow = 1'b0;
  logic [BLOCK_ROWS-1:0] pipe;

  int epoch = 0;
  int seen_epoch = 0;
  int exp_reads = 0;
  int cyc = 0;
  bit prev_re = 1'b0;
  int reads = 0;
  int writes = 0;
  int en_cnt = 0;
  int en_first_we = 0;
  int first_read_cyc = 0;
  int last_read_cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int bad_en = 0;

  assign ifc.in_fifo_empty         = (in_pushed == in_popped);
  assign ifc.core_start_next_stage = pipe[BLOCK_ROWS-1];

  // Input FIFO pops and the core's valid-row pipeline.
  always @(posedge clk) begin
    if (ifc.in_fifo_re) in_popped <= in_popped + 1;
    if (rst) pipe <= '0;
    else if (ifc.core_clk_en) pipe <= {pipe[BLOCK_ROWS-2:0], ifc.core_start};
  end

  // Output FIFO occupancy; flags any push beyond DEPTH entries.
  always @(posedge clk) begin
    occ <= occ + int'(ifc.out_fifo_we) - int'(ifc.out_fifo_re && (occ > 0));
    if (occ + int'(ifc.out_fifo_we) - int'(ifc.out_fifo_re && (occ > 0)) > DEPTH)
      overflow <= 1'b1;
  end

  // Per-epoch event counters and enable/start consistency tracking.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_re <= ifc.in_fifo_re;
    if (seen_epoch != epoch) begin
      seen_epoch  <= epoch;
      reads       <= 0;
      writes      <= 0;
      en_cnt      <= 0;
      en_first_we <= 0;
      done_cnt    <= 0;
      bad_en      <= 0;
    end else begin
      if (ifc.in_fifo_re) begin
        if (reads == 0) first_read_cyc <= cyc;
        last_read_cyc <= cyc;
        reads <= reads + 1;
      end
      if (ifc.core_clk_en) en_cnt <= en_cnt + 1;
      if (ifc.out_fifo_we) begin
        if (writes == 0) en_first_we <= en_cnt + 1;
        writes      <= writes + 1;
        last_we_cyc <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      bad_en <= bad_en + int'(ifc.core_start != prev_re)
                       + int'(ifc.core_start && !ifc.core_clk_en)
                       + int'(ifc.core_clk_en && !ifc.core_start && (reads < exp_reads));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [LEN_W-1:0] len);
    ctx_start  = 1'b1;
    ctx_length = len;
    @(negedge clk);
    ctx_start  = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    @(negedge clk);
  endtask

  task automatic waitWrites(input int target, input int max_cycles, input string tag);
    int n;
    n = 0;
    while (writes < target && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_writes_reached"}, 32'(writes >= target), 32'd1);
  endtask

  initial begin
    int fed;
    int n;
    rst             = 1'b1;
    ctx_start       = 1'b0;
    ctx_length      = '0;
    ifc.out_fifo_re = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_in_fifo_re", 32'(ifc.in_fifo_re), 32'd0);
    checkOutput("rst_core_clk_en", 32'(ifc.core_clk_en), 32'd0);
    checkOutput("rst_core_start", 32'(ifc.core_start), 32'd0);
    checkOutput("rst_out_fifo_we", 32'(ifc.out_fifo_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    checkOutput("rst_credits", 32'(dut.u_credits.credits), 32'd8);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic 32-row context, pops held high");
    epoch = 1; exp_reads = 32; in_pushed += 32; ifc.out_fifo_re = 1'b1;
    @(negedge clk);
    applyStimulus(32);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    applyStimulus(40);
    checkOutput("t6_ignored_start_len_err", 32'(len_err), 32'd0);
    checkOutput("t6_ignored_start_busy", 32'(busy), 32'd1);
    n = 0;
    while (!(writes >= 3 && ifc.out_fifo_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_push_pop_same_cycle", 32'(ifc.out_fifo_we && ifc.out_fifo_re), 32'd1);
    checkOutput("t6_credits_hold", 32'(dut.u_credits.credits), 32'd7);
    waitDone(300, "t1");
    checkOutput("t1_reads", 32'(reads), 32'd32);
    checkOutput("t1_read_span", 32'(last_read_cyc - first_read_cyc), 32'd31);
    checkOutput("t1_first_write_en_idx", 32'(en_first_we), 32'd33);
    checkOutput("t1_writes", 32'(writes), 32'd32);
    checkOutput("t1_done_after_last_write", 32'(done_cyc - last_we_cyc), 32'd2);
    checkOutput("t1_en_start_rules", 32'(bad_en), 32'd0);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_done_after", 32'(done), 32'd0);
    checkOutput("t1_credits_end", 32'(dut.u_credits.credits), 32'd8);

    $display("[TB] 64-row context with output backpressure");
    epoch = 2; exp_reads = 64; in_pushed += 64; ifc.out_fifo_re = 1'b0;
    @(negedge clk);
    applyStimulus(64);
    waitWrites(8, 300, "t2");
    repeat (10) @(negedge clk);
    checkOutput("t2_stall_writes", 32'(writes), 32'd8);
    checkOutput("t2_stall_reads", 32'(reads), 32'd40);
    checkOutput("t2_stall_en_cycles", 32'(en_cnt), 32'd40);
    checkOutput("t2_stall_credits", 32'(dut.u_credits.credits), 32'd0);
    checkOutput("t2_stall_clk_en", 32'(ifc.core_clk_en), 32'd0);
    repeat (4) begin
      ifc.out_fifo_re = 1'b1;
      @(negedge clk);
    end
    ifc.out_fifo_re = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t2_four_pops_writes", 32'(writes), 32'd12);
    checkOutput("t2_four_pops_reads", 32'(reads), 32'd44);
    checkOutput("t2_four_pops_credits", 32'(dut.u_credits.credits), 32'd0);
    ifc.out_fifo_re = 1'b1;
    waitDone(400, "t2");
    checkOutput("t2_writes", 32'(writes), 32'd64);
    checkOutput("t2_reads", 32'(reads), 32'd64);
    checkOutput("t2_no_overflow", 32'(overflow), 32'd0);

    $display("[TB] input starvation, one row every third cycle");
    epoch = 3; exp_reads = 32;
    @(negedge clk);
    applyStimulus(32);
    fed = 0;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      if ((n % 3) == 0 && fed < 32) begin
        in_pushed++;
        fed++;
      end
      @(negedge clk);
      n++;
    end
    checkOutput("t3_done_seen", 32'(done_cnt != 0), 32'd1);
    @(negedge clk);
    checkOutput("t3_reads", 32'(reads), 32'd32);
    checkOutput("t3_read_span", 32'(last_read_cyc - first_read_cyc), 32'd93);
    checkOutput("t3_en_only_after_read", 32'(bad_en), 32'd0);
    checkOutput("t3_first_write_en_idx", 32'(en_first_we), 32'd33);
    checkOutput("t3_writes", 32'(writes), 32'd32);
    checkOutput("t3_done_after_last_write", 32'(done_cyc - last_we_cyc), 32'd2);

    $display("[TB] zero and non-multiple lengths");
    epoch = 4; exp_reads = 0;
    @(negedge clk);
    applyStimulus(0);
    checkOutput("t4_len0_done", 32'(done), 32'd1);
    checkOutput("t4_len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_len0_done_pulse", 32'(done), 32'd0);
    applyStimulus(40);
    checkOutput("t4_len40_err", 32'(len_err), 32'd1);
    checkOutput("t4_len40_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t4_no_reads", 32'(reads), 32'd0);
    checkOutput("t4_len_err_sticky", 32'(len_err), 32'd1);
    checkOutput("t4_len40_idle", 32'(busy), 32'd0);

    $display("[TB] reset during drain bubbles");
    epoch = 5; exp_reads = 32; in_pushed += 32; ifc.out_fifo_re = 1'b1;
    @(negedge clk);
    applyStimulus(32);
    checkOutput("t5_len_err_cleared", 32'(len_err), 32'd0);
    waitWrites(5, 300, "t5");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_in_fifo_re", 32'(ifc.in_fifo_re), 32'd0);
    checkOutput("t5_rst_core_clk_en", 32'(ifc.core_clk_en), 32'd0);
    checkOutput("t5_rst_core_start", 32'(ifc.core_start), 32'd0);
    checkOutput("t5_rst_out_fifo_we", 32'(ifc.out_fifo_we), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_done", 32'(done), 32'd0);
    checkOutput("t5_rst_credits", 32'(dut.u_credits.credits), 32'd8);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    epoch = 6; in_pushed += 32;
    @(negedge clk);
    applyStimulus(32);
    waitDone(300, "t5");
    checkOutput("t5_fresh_writes", 32'(writes), 32'd32);
    checkOutput("t5_fresh_reads", 32'(reads), 32'd32);
    checkOutput("t5_fresh_first_write_en_idx", 32'(en_first_we), 32'd33);
    checkOutput("t5_no_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
